// File: rtl/credit_fifo_writer_pkg.sv
// Shared types and helpers for the credit-based FIFO writer.
package credit_fifo_writer_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/credit_fifo_writer_credit_counter.sv
// Saturating up/down credit counter that resets to DEPTH.
module credit_counter
    import credit_fifo_writer_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = cnt_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 zero_o,
    output logic                 full_o,
    output logic                 overflow_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(DEPTH);

    // Simultaneous inc and dec cancel; both ends saturate.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= MAX_CNT;
        end else if (inc_i && !dec_i && !full_o) begin
            count_o <= count_o + CNT_WIDTH'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            count_o <= count_o - CNT_WIDTH'(1);
        end
    end

    assign zero_o     = (count_o == '0);
    assign full_o     = (count_o == MAX_CNT);
    assign overflow_o = inc_i && !dec_i && full_o;

endmodule

// File: rtl/credit_fifo_writer.sv
// Credit-tracking write endpoint for a remote FIFO, with drain handshake.
// Define CREDIT_FIFO_WRITER_ASSERT_EN to enable simulation-only assertions.
module credit_fifo_writer
    import credit_fifo_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  dtype                 data_i,
    output logic                 push_o,
    output dtype                 data_o,
    input  logic                 credit_i,
    input  logic                 drain_i,
    output logic                 drain_done_o,
    output logic [CNT_WIDTH-1:0] credits_o,
    output logic                 idle_o,
    output logic                 err_o
);

    state_e state;
    logic   accept;
    logic   cnt_zero;
    logic   cnt_full;
    logic   cnt_overflow;
    logic   next_full;

    credit_counter #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_credit_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inc_i      (credit_i),
        .dec_i      (accept),
        .count_o    (credits_o),
        .zero_o     (cnt_zero),
        .full_o     (cnt_full),
        .overflow_o (cnt_overflow)
    );

    // Ready comes from registered state only so credit_i never bypasses.
    assign ready_o = (state == RUN) && !cnt_zero;
    assign accept  = valid_i && ready_o;
    assign idle_o  = cnt_full && !push_o;

    // Whether the counter will read DEPTH after this edge.
    assign next_full = cnt_full ? !(accept && !credit_i)
                                : ((credits_o == CNT_WIDTH'(DEPTH - 1)) && credit_i && !accept);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= RUN;
            push_o       <= 1'b0;
            data_o       <= '0;
            drain_done_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            push_o       <= accept;
            drain_done_o <= 1'b0;
            if (accept) begin
                data_o <= data_i;
            end
            if (cnt_overflow) begin
                err_o <= 1'b1;
            end
            case (state)
                RUN: begin
                    if (drain_i) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (next_full && !push_o) begin
                        state        <= DONE;
                        drain_done_o <= 1'b1;
                    end
                end
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef CREDIT_FIFO_WRITER_ASSERT_EN
    if (DEPTH < 1) begin : g_depth_chk
        $fatal(1, "credit_fifo_writer: DEPTH must be >= 1");
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(credit_i && !accept && cnt_full))
        else $fatal(1, "credit_fifo_writer: credit returned with all credits home");

    a_no_accept_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(accept && cnt_zero))
        else $fatal(1, "credit_fifo_writer: accept with zero credits");

    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_i && !ready_o) |=> (!valid_i || $stable(data_i)))
        else $error("credit_fifo_writer: data_i changed while stalled");
`else
    // Overflow is still reported through err_o without assertions.
`endif

endmodule

// File: tb/tb_credit_fifo_writer.sv
// Randomized self-checking bench for credit_fifo_writer against a behavioural model.
module tb_credit_fifo_writer;

    localparam int DEPTH = 4;
    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_DONE = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data_i = '0;
    logic        push_o;
    logic [31:0] data_o;
    logic        credit_i = 1'b0;
    logic        drain_i = 1'b0;
    logic        drain_done_o;
    logic [2:0]  credits_o;
    logic        idle_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state
    int          m_cred;
    int          m_ph;
    bit          m_push;
    logic [31:0] m_data;
    bit          m_err;
    bit          m_done;

    credit_fifo_writer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .push_o       (push_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .drain_i      (drain_i),
        .drain_done_o (drain_done_o),
        .credits_o    (credits_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cred = DEPTH; m_ph = PH_RUN; m_push = 0; m_data = '0; m_err = 0; m_done = 0;
    endtask

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en && rst_ni) begin
            chk("ready_o", 32'(ready_o), 32'((m_ph == PH_RUN) && (m_cred != 0)));
            chk("push_o", 32'(push_o), 32'(m_push));
            chk("data_o", data_o, m_data);
            chk("credits_o", 32'(credits_o), 32'(m_cred));
            chk("idle_o", 32'(idle_o), 32'((m_cred == DEPTH) && !m_push));
            chk("err_o", 32'(err_o), 32'(m_err));
            chk("drain_done_o", 32'(drain_done_o), 32'(m_done));
        end
    end

    // Drive one cycle of inputs and advance the model by the behavioural rules.
    task automatic step(input bit v, input logic [31:0] d, input bit c, input bit dr);
        bit acc;
        int nc;
        valid_i = v; data_i = d; credit_i = c; drain_i = dr;
        @(posedge clk_i);
        acc = v && (m_ph == PH_RUN) && (m_cred != 0);
        nc  = m_cred;
        if (acc && !c) nc--;
        else if (c && !acc) begin
            if (m_cred == DEPTH) m_err = 1;
            else nc++;
        end
        m_done = 0;
        case (m_ph)
            PH_RUN:   if (dr) m_ph = PH_DRAIN;
            PH_DRAIN: if (nc == DEPTH && !m_push) begin m_ph = PH_DONE; m_done = 1; end
            default:  m_ph = PH_RUN;
        endcase
        m_push = acc;
        if (acc) m_data = d;
        m_cred = nc;
        @(negedge clk_i);
    endtask

    initial begin
        logic [31:0] dv [4];
        dv[0] = 32'hA000_0000; dv[1] = 32'hA000_0001; dv[2] = 32'hA000_0002; dv[3] = 32'hA000_0003;

        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        chk("rst credits", 32'(credits_o), 32'd4);
        chk("rst ready", 32'(ready_o), 32'd1);
        chk("rst push", 32'(push_o), 32'd0);
        chk("rst data", data_o, 32'd0);
        chk("rst err", 32'(err_o), 32'd0);
        chk("rst idle", 32'(idle_o), 32'd1);
        chk("rst done", 32'(drain_done_o), 32'd0);
        chk_en = 1'b1;

        // Burst of four accepts, fifth stalls.
        for (int i = 0; i < 4; i++) begin
            step(1, dv[i], 0, 0);
            chk("burst push", 32'(push_o), 32'd1);
            chk("burst data", data_o, dv[i]);
            chk("burst credits", 32'(credits_o), 32'(3 - i));
        end
        chk("burst ready low", 32'(ready_o), 32'd0);
        step(1, 32'hDEAD_BEEF, 0, 0);
        chk("stall push", 32'(push_o), 32'd0);
        chk("stall data hold", data_o, dv[3]);

        // Single credit at zero: one-cycle bubble then one accept.
        step(0, 0, 1, 0);
        chk("credit back", 32'(credits_o), 32'd1);
        chk("credit ready", 32'(ready_o), 32'd1);
        step(1, 32'h1234_5678, 0, 0);
        chk("single accept credits", 32'(credits_o), 32'd0);
        chk("single accept data", data_o, 32'h1234_5678);

        // Accept and credit together hold the count.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, $urandom, 1, 0);
            chk("balanced credits", 32'(credits_o), 32'd2);
            chk("balanced push", 32'(push_o), 32'd1);
        end

        // Overflow saturates and sets the sticky error.
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("ovf credits", 32'(credits_o), 32'd4);
        chk("ovf err", 32'(err_o), 32'd1);
        step(0, 0, 0, 0);
        chk("ovf err sticky", 32'(err_o), 32'd1);

        // Drain from credits=1 with credits returning two cycles apart.
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("drain ready low", 32'(ready_o), 32'd0);
            step(1, $urandom, 1, 0);
            if (i < 2) begin
                chk("drain not done", 32'(drain_done_o), 32'd0);
                step(1, $urandom, 0, 0);
            end
        end
        chk("drain credits home", 32'(credits_o), 32'd4);
        chk("drain done pulse", 32'(drain_done_o), 32'd1);
        chk("drain done ready", 32'(ready_o), 32'd0);
        step(0, 0, 0, 0);
        chk("drain done cleared", 32'(drain_done_o), 32'd0);
        chk("drain ready back", 32'(ready_o), 32'd1);

        // Asynchronous reset while draining with two credits out.
        step(1, $urandom, 0, 0);
        step(1, $urandom, 0, 1);
        step(0, 0, 0, 0);
        chk("pre-reset credits", 32'(credits_o), 32'd2);
        chk_en = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("async rst credits", 32'(credits_o), 32'd4);
        chk("async rst push", 32'(push_o), 32'd0);
        chk("async rst done", 32'(drain_done_o), 32'd0);
        chk("async rst ready", 32'(ready_o), 32'd1);
        chk("async rst err", 32'(err_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk_en = 1'b1;

        // Randomized traffic, credits, and drains.
        for (int n = 0; n < 3000; n++) begin
            bit v, c, dr;
            v  = ($urandom_range(0, 3) != 0);
            c  = (m_cred < DEPTH) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
            dr = ($urandom_range(0, 29) == 0);
            step(v, $urandom, c, dr);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
